entrada_numero_bcd: RTL and testbench
=====================================

Name: entrada_numero_bcd

Overview:
Parametrised keypad number-entry controller for the calculator datapath. Collects up to DIGITS BCD digits per operand, with backspace, clear and enter keys. Commits two operands in sequence (A, then B) and presents them to the ALU stage with a ready/ack handshake. Drives the display bus with the number currently being typed.

Parameters:
DIGITS, 4, max BCD digits per operand (1..8)
CW, $clog2(DIGITS+1), derived width of the digit counter (localparam)

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
tecla_valida  in  1  high while a key is held; already debounced and synchronous to clk
tecla_cod  in  4  key code: 0-9 digit, 4'hA enter, 4'hB borrar (backspace), 4'hC limpiar (clear), others ignored
ack  in  1  ALU stage has consumed the operand pair
numero  out  4*DIGITS  BCD value being typed; least significant digit in [3:0]
cant_digitos  out  CW  digits currently entered
operando_idx  out  1  0 = typing A, 1 = typing B
operando_a  out  4*DIGITS  committed operand A (BCD)
operando_b  out  4*DIGITS  committed operand B (BCD)
par_listo  out  1  operand pair valid
desborde  out  1  one-cycle pulse on a rejected digit

Behaviour:
- Clock and reset: one clock domain. Reset is synchronous, active-high. On reset all outputs are 0 and the state is ENTRADA; prev_valida = 0. Reset mid-operation discards any partial entry and committed operands at the next edge.
- Key events: evento = tecla_valida & ~prev_valida, where prev_valida is registered each cycle in every state, including LISTO. A held key produces exactly one event. Events only act in state ENTRADA.
- States: ENTRADA, COMMIT, LISTO.
- ENTRADA, digit d (0-9):
  - cant_digitos == DIGITS: numero unchanged; desborde = 1 for the next cycle.
  - cant_digitos == 0 and d == 0: ignored; no leading zeros, numero stays 0.
  - Otherwise: numero <= {numero[4*DIGITS-5:0], d}; cant_digitos++. Visible the cycle after the event.
- ENTRADA, borrar: if cant_digitos > 0, numero shifts right 4 with zero fill and cant_digitos--. Otherwise no-op.
- ENTRADA, limpiar: numero <= 0; cant_digitos <= 0; operando_idx unchanged.
- ENTRADA, enter: next state COMMIT. An empty entry commits value 0.
- ENTRADA, codes 4'hD-4'hF: ignored (4'hD is reserved, see Optional Feature).
- COMMIT (exactly one cycle):
  - operando_idx == 0: operando_a <= numero; operando_idx <= 1; numero and cant_digitos cleared; next state ENTRADA.
  - operando_idx == 1: operando_b <= numero; next state LISTO.
- LISTO:
  - par_listo = 1 (registered). Key events are dropped.
  - On ack: par_listo <= 0; operando_idx <= 0; numero and cant_digitos cleared; next state ENTRADA.
  - operando_a and operando_b hold their values until overwritten by the next COMMIT.
- Latency: enter event in cycle n -> COMMIT in n+1 -> par_listo high in n+2 (for operand B).
- Simultaneous events: in LISTO, ack with a key event -> ack wins and the event is dropped. ack outside LISTO is ignored.
- Outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: ENTRADA_SIGNO_EN.
- Defined:
  - Key 4'hD toggles a sign bit for the current entry in ENTRADA; limpiar clears it.
  - Adds outputs signo (current sign), signo_a and signo_b, latched in COMMIT.
  - A sign applied to an empty entry is kept, so enter commits -0, which is presented as signo = 0.
- Not defined: 4'hD is ignored and none of the sign ports exist.

Decomposition:
- Package entrada_pkg holds:
  - key-code constants: TECLA_ENTER = 4'hA, TECLA_BORRAR = 4'hB, TECLA_LIMPIAR = 4'hC, TECLA_SIGNO = 4'hD;
  - state encoding: ENTRADA = 2'b00, COMMIT = 2'b01, LISTO = 2'b10.
- One sub-module: detector_flanco (rising-edge detector with synchronous reset), instantiated on tecla_valida.

Test Plan:
- Reset, then digits 1,2,3 each held 3 cycles -> numero = 16'h0123, cant_digitos = 3, one event per key.
- DIGITS=4, press 9,8,7,6,5 -> numero = 16'h9876, desborde pulses once on the fifth key; then borrar -> 16'h0987, cant_digitos = 3.
- Press 0,0,4, enter, 7, enter -> operando_a = 16'h0004, operando_b = 16'h0007, par_listo high 2 cycles after the second enter; ack -> par_listo = 0, operando_idx = 0.
- In LISTO press 5 together with ack -> digit dropped, numero = 0, state ENTRADA.
- Type 4,2, assert reset for one cycle -> all outputs 0; a subsequent press of 3 gives numero = 16'h0003.
- With ENTRADA_SIGNO_EN: press 5, 4'hD, enter -> operando_a = 16'h0005, signo_a = 1; then limpiar -> signo = 0.

Source files
------------

// File: rtl/entrada_pkg.sv
// Shared definitions for the keypad number-entry controller:
// key codes, FSM state encoding and a small key classification helper.
package entrada_pkg;

    localparam logic [3:0] TECLA_ENTER   = 4'hA;
    localparam logic [3:0] TECLA_BORRAR  = 4'hB;
    localparam logic [3:0] TECLA_LIMPIAR = 4'hC;
    localparam logic [3:0] TECLA_SIGNO   = 4'hD;

    typedef enum logic [1:0] {
        ENTRADA = 2'b00,
        COMMIT  = 2'b01,
        LISTO   = 2'b10
    } estado_t;

    // Codes 0..9 are decimal digit keys.
    function automatic logic es_digito(input logic [3:0] cod);
        return (cod <= 4'd9);
    endfunction

endpackage

// File: rtl/detector_flanco.sv
// Rising-edge detector: one-cycle pulse on the first cycle the input is high.
// The previous-sample register runs every cycle regardless of who consumes
// the pulse, so a held key can never produce a second event.
module detector_flanco (
    input  logic clk,
    input  logic reset,
    input  logic entrada,
    output logic flanco
);

    logic prev_reg;

    // Register the previous input sample; cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_reg <= 1'b0;
        end else begin
            prev_reg <= entrada;
        end
    end

    assign flanco = entrada & ~prev_reg;

endmodule

// File: rtl/entrada_numero_bcd.sv
// Keypad number-entry controller. Collects up to DIGITS BCD digits per
// operand with backspace/clear/enter, commits operand A then B, and holds
// the pair for the ALU stage until ack.
// Optional feature macro: ENTRADA_SIGNO_EN (sign key 4'hD and sign outputs).
module entrada_numero_bcd
    import entrada_pkg::*;
#(
    parameter  int DIGITS = 4,
    localparam int CW     = $clog2(DIGITS + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tecla_valida,
    input  logic [3:0]            tecla_cod,
    input  logic                  ack,
    output logic [4*DIGITS-1:0]   numero,
    output logic [CW-1:0]         cant_digitos,
    output logic                  operando_idx,
    output logic [4*DIGITS-1:0]   operando_a,
    output logic [4*DIGITS-1:0]   operando_b,
    output logic                  par_listo,
`ifdef ENTRADA_SIGNO_EN
    output logic                  signo,
    output logic                  signo_a,
    output logic                  signo_b,
`endif
    output logic                  desborde
);

    localparam int NW = 4 * DIGITS;

    logic evento;

    estado_t         state_reg,    state_next;
    logic [NW-1:0]   numero_reg,   numero_next;
    logic [CW-1:0]   cant_reg,     cant_next;
    logic            idx_reg,      idx_next;
    logic [NW-1:0]   op_a_reg,     op_a_next;
    logic [NW-1:0]   op_b_reg,     op_b_next;
    logic            listo_reg,    listo_next;
    logic            desborde_reg, desborde_next;
`ifdef ENTRADA_SIGNO_EN
    logic            signo_reg,    signo_next;
    logic            signo_a_reg,  signo_a_next;
    logic            signo_b_reg,  signo_b_next;
    logic            signo_efectivo;
`endif

    detector_flanco u_detector (
        .clk     (clk),
        .reset   (reset),
        .entrada (tecla_valida),
        .flanco  (evento)
    );

`ifdef ENTRADA_SIGNO_EN
    // A negative zero is committed as a positive zero.
    assign signo_efectivo = signo_reg & (numero_reg != '0);
`endif

    // State register and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ENTRADA;
            numero_reg   <= '0;
            cant_reg     <= '0;
            idx_reg      <= 1'b0;
            op_a_reg     <= '0;
            op_b_reg     <= '0;
            listo_reg    <= 1'b0;
            desborde_reg <= 1'b0;
`ifdef ENTRADA_SIGNO_EN
            signo_reg    <= 1'b0;
            signo_a_reg  <= 1'b0;
            signo_b_reg  <= 1'b0;
`endif
        end else begin
            state_reg    <= state_next;
            numero_reg   <= numero_next;
            cant_reg     <= cant_next;
            idx_reg      <= idx_next;
            op_a_reg     <= op_a_next;
            op_b_reg     <= op_b_next;
            listo_reg    <= listo_next;
            desborde_reg <= desborde_next;
`ifdef ENTRADA_SIGNO_EN
            signo_reg    <= signo_next;
            signo_a_reg  <= signo_a_next;
            signo_b_reg  <= signo_b_next;
`endif
        end
    end

    // Next-state and datapath update; key events only act in ENTRADA.
    always_comb begin
        state_next    = state_reg;
        numero_next   = numero_reg;
        cant_next     = cant_reg;
        idx_next      = idx_reg;
        op_a_next     = op_a_reg;
        op_b_next     = op_b_reg;
        listo_next    = listo_reg;
        desborde_next = 1'b0;
`ifdef ENTRADA_SIGNO_EN
        signo_next    = signo_reg;
        signo_a_next  = signo_a_reg;
        signo_b_next  = signo_b_reg;
`endif

        case (state_reg)
            ENTRADA: begin
                if (evento) begin
                    if (es_digito(tecla_cod)) begin
                        if (cant_reg == CW'(DIGITS)) begin
                            desborde_next = 1'b1;
                        end else if (!(cant_reg == '0 && tecla_cod == 4'd0)) begin
                            numero_next = (numero_reg << 4) | NW'(tecla_cod);
                            cant_next   = cant_reg + CW'(1);
                        end
                    end else if (tecla_cod == TECLA_BORRAR) begin
                        if (cant_reg != '0) begin
                            numero_next = numero_reg >> 4;
                            cant_next   = cant_reg - CW'(1);
                        end
                    end else if (tecla_cod == TECLA_LIMPIAR) begin
                        numero_next = '0;
                        cant_next   = '0;
`ifdef ENTRADA_SIGNO_EN
                        signo_next  = 1'b0;
`endif
                    end else if (tecla_cod == TECLA_ENTER) begin
                        state_next = COMMIT;
`ifdef ENTRADA_SIGNO_EN
                    end else if (tecla_cod == TECLA_SIGNO) begin
                        signo_next = ~signo_reg;
`endif
                    end
                end
            end

            COMMIT: begin
                if (!idx_reg) begin
                    op_a_next    = numero_reg;
                    idx_next     = 1'b1;
                    numero_next  = '0;
                    cant_next    = '0;
`ifdef ENTRADA_SIGNO_EN
                    signo_a_next = signo_efectivo;
                    signo_next   = 1'b0;
`endif
                    state_next   = ENTRADA;
                end else begin
                    op_b_next    = numero_reg;
                    listo_next   = 1'b1;
`ifdef ENTRADA_SIGNO_EN
                    signo_b_next = signo_efectivo;
`endif
                    state_next   = LISTO;
                end
            end

            LISTO: begin
                if (ack) begin
                    listo_next  = 1'b0;
                    idx_next    = 1'b0;
                    numero_next = '0;
                    cant_next   = '0;
`ifdef ENTRADA_SIGNO_EN
                    signo_next  = 1'b0;
`endif
                    state_next  = ENTRADA;
                end
            end

            default: begin
                state_next = ENTRADA;
            end
        endcase
    end

    assign numero       = numero_reg;
    assign cant_digitos = cant_reg;
    assign operando_idx = idx_reg;
    assign operando_a   = op_a_reg;
    assign operando_b   = op_b_reg;
    assign par_listo    = listo_reg;
    assign desborde     = desborde_reg;
`ifdef ENTRADA_SIGNO_EN
    assign signo        = signo_reg;
    assign signo_a      = signo_a_reg;
    assign signo_b      = signo_b_reg;
`endif

endmodule

// File: tb/tb_entrada_numero_bcd.sv
// Directed testbench for entrada_numero_bcd (DIGITS = 4).
// Build with ENTRADA_SIGNO_EN defined to also exercise the sign key.
module tb_entrada_numero_bcd;

    localparam int DIGITS = 4;
    localparam int CW     = $clog2(DIGITS + 1);

    logic              clk = 1'b0;
    logic              reset;
    logic              tecla_valida;
    logic [3:0]        tecla_cod;
    logic              ack;
    logic [15:0]       numero;
    logic [CW-1:0]     cant_digitos;
    logic              operando_idx;
    logic [15:0]       operando_a;
    logic [15:0]       operando_b;
    logic              par_listo;
    logic              desborde;
`ifdef ENTRADA_SIGNO_EN
    logic              signo;
    logic              signo_a;
    logic              signo_b;
`endif

    int checks = 0;
    int errors = 0;
    int desborde_cnt = 0;
    int cnt_antes;

    entrada_numero_bcd #(.DIGITS(DIGITS)) dut (
        .clk          (clk),
        .reset        (reset),
        .tecla_valida (tecla_valida),
        .tecla_cod    (tecla_cod),
        .ack          (ack),
        .numero       (numero),
        .cant_digitos (cant_digitos),
        .operando_idx (operando_idx),
        .operando_a   (operando_a),
        .operando_b   (operando_b),
        .par_listo    (par_listo),
`ifdef ENTRADA_SIGNO_EN
        .signo        (signo),
        .signo_a      (signo_a),
        .signo_b      (signo_b),
`endif
        .desborde     (desborde)
    );

    always #5 clk = ~clk;

    // Count overflow pulses, sampled away from the active edge.
    always @(negedge clk) begin
        if (desborde === 1'b1) desborde_cnt <= desborde_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    // Press a key for 'hold' cycles, then release for one cycle.
    task automatic press(input logic [3:0] cod, input int hold);
        @(negedge clk);
        tecla_cod    = cod;
        tecla_valida = 1'b1;
        repeat (hold) @(negedge clk);
        tecla_valida = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        reset        = 1'b1;
        tecla_valida = 1'b0;
        tecla_cod    = 4'h0;
        ack          = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Reset state
        check("rst numero", 32'(numero), 32'h0);
        check("rst cant", 32'(cant_digitos), 32'd0);
        check("rst idx", 32'(operando_idx), 32'd0);
        check("rst par_listo", 32'(par_listo), 32'd0);
        check("rst desborde", 32'(desborde), 32'd0);
        check("rst op_a", 32'(operando_a), 32'h0);

        // Held keys give exactly one event each
        press(4'd1, 3); press(4'd2, 3); press(4'd3, 3);
        check("123 numero", 32'(numero), 32'h0123);
        check("123 cant", 32'(cant_digitos), 32'd3);

        // Overflow and backspace
        press(4'hC, 1);
        press(4'd9, 1); press(4'd8, 1); press(4'd7, 1); press(4'd6, 1);
        check("full numero", 32'(numero), 32'h9876);
        cnt_antes = desborde_cnt;
        press(4'd5, 1);
        check("ovf numero", 32'(numero), 32'h9876);
        check("ovf pulses", 32'(desborde_cnt - cnt_antes), 32'd1);
        press(4'hB, 1);
        check("borrar numero", 32'(numero), 32'h0987);
        check("borrar cant", 32'(cant_digitos), 32'd3);

        // Leading zeros, commit A then B, latency, ack
        press(4'hC, 1);
        press(4'd0, 1); press(4'd0, 1); press(4'd4, 1);
        check("004 numero", 32'(numero), 32'h0004);
        check("004 cant", 32'(cant_digitos), 32'd1);
        press(4'hA, 1);
        check("commitA op_a", 32'(operando_a), 32'h0004);
        check("commitA idx", 32'(operando_idx), 32'd1);
        check("commitA numero", 32'(numero), 32'h0);
        press(4'd7, 1);
        @(negedge clk);
        tecla_cod = 4'hA; tecla_valida = 1'b1;
        @(negedge clk);
        check("lat n+1 par_listo", 32'(par_listo), 32'd0);
        @(negedge clk);
        tecla_valida = 1'b0;
        check("lat n+2 par_listo", 32'(par_listo), 32'd1);
        check("commitB op_b", 32'(operando_b), 32'h0007);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        check("ack par_listo", 32'(par_listo), 32'd0);
        check("ack idx", 32'(operando_idx), 32'd0);
        check("ack op_a held", 32'(operando_a), 32'h0004);

        // LISTO: keys dropped; ack together with a key wins
        press(4'd1, 1); press(4'hA, 1);
        press(4'd2, 1); press(4'hA, 1);
        check("listo2 par_listo", 32'(par_listo), 32'd1);
        press(4'd5, 1);
        check("listo drop numero", 32'(numero), 32'h0002);
        @(negedge clk);
        ack = 1'b1; tecla_cod = 4'd5; tecla_valida = 1'b1;
        @(negedge clk);
        ack = 1'b0; tecla_valida = 1'b0;
        @(negedge clk);
        check("ack+key numero", 32'(numero), 32'h0);
        check("ack+key cant", 32'(cant_digitos), 32'd0);
        check("ack+key par_listo", 32'(par_listo), 32'd0);
        press(4'd6, 1);
        check("after ack entrada", 32'(numero), 32'h0006);

        // Reset mid-entry
        press(4'hC, 1);
        press(4'd4, 1); press(4'd2, 1);
        check("42 numero", 32'(numero), 32'h0042);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst2 numero", 32'(numero), 32'h0);
        check("rst2 cant", 32'(cant_digitos), 32'd0);
        check("rst2 op_a", 32'(operando_a), 32'h0);
        check("rst2 op_b", 32'(operando_b), 32'h0);
        check("rst2 idx", 32'(operando_idx), 32'd0);
        press(4'd3, 1);
        check("rst2 press3", 32'(numero), 32'h0003);

`ifdef ENTRADA_SIGNO_EN
        // Sign key
        press(4'hC, 1);
        press(4'd5, 1); press(4'hD, 1);
        check("signo set", 32'(signo), 32'd1);
        press(4'hA, 1);
        check("signo op_a", 32'(operando_a), 32'h0005);
        check("signo_a", 32'(signo_a), 32'd1);
        press(4'hD, 1);
        check("signo again", 32'(signo), 32'd1);
        press(4'hC, 1);
        check("limpiar signo", 32'(signo), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
